// File: rtl/addr_decoder_ws.sv
// Programmable chip-select decoder with per-region wait states.
// An ALE-latched address is matched against a base/mask region table and drives one active-low chip select.
module addr_decoder_ws #(
  parameter int unsigned AW  = 16,
  parameter int unsigned NCS = 8,
  parameter int unsigned WSW = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [AW-1:0]  address,
  input  logic           MIO,
  input  logic           ALE,
  input  logic           bus_done,
  input  logic           cfg_we,
  input  logic [3:0]     cfg_idx,
  input  logic [AW-1:0]  cfg_base,
  input  logic [AW-1:0]  cfg_mask,
  input  logic           cfg_mio,
  input  logic [WSW-1:0] cfg_ws,
  input  logic           cfg_en,
  output logic [NCS-1:0] cs,
  output logic           ready,
  output logic           err
);

  localparam int unsigned IW = (NCS > 1) ? $clog2(NCS) : 1;

  typedef enum logic [1:0] {IDLE, DECODE, WAIT, ACTIVE} state_t;

  state_t          state, state_d;
  logic [NCS-1:0]  cs_d;
  logic            ready_d, err_d;
  logic [WSW-1:0]  cnt, cnt_d;
  logic [AW-1:0]   addr_q;
  logic            mio_q;

  logic [AW-1:0]   r_base [NCS];
  logic [AW-1:0]   r_mask [NCS];
  logic [WSW-1:0]  r_ws   [NCS];
  logic [NCS-1:0]  r_mio, r_en;

  logic            hit;
  logic [IW-1:0]   win;
  logic [WSW-1:0]  win_ws;
  logic [NCS-1:0]  cs_hit;

  // Region table; indices at or beyond NCS never match the loop and are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mio <= '0;
      r_en  <= '0;
      for (int unsigned i = 0; i < NCS; i++) begin
        r_base[i] <= '0;
        r_mask[i] <= '0;
        r_ws[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCS; i++) begin
        if (cfg_we && (cfg_idx == 4'(i))) begin
          r_base[i] <= cfg_base;
          r_mask[i] <= cfg_mask;
          r_ws[i]   <= cfg_ws;
          r_mio[i]  <= cfg_mio;
          r_en[i]   <= cfg_en;
        end
      end
    end
  end

  // Priority match: first (lowest-index) hit is kept.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int unsigned i = 0; i < NCS; i++) begin
      if (!hit && r_en[i] && (r_mio[i] == mio_q) &&
          (((addr_q ^ r_base[i]) & r_mask[i]) == '0)) begin
        hit = 1'b1;
        win = IW'(i);
      end
    end
  end

  assign win_ws = r_ws[win];
  assign cs_hit = ~(NCS'(1) << win);

  always_comb begin
    state_d = state;
    cs_d    = cs;
    ready_d = ready;
    err_d   = 1'b0;
    cnt_d   = cnt;
    if (ALE) begin
      state_d = DECODE;
      cs_d    = '1;
      ready_d = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cs_d    = '1;
          ready_d = 1'b0;
        end
        DECODE: begin
          if (hit) begin
            cs_d    = cs_hit;
            cnt_d   = win_ws;
            ready_d = 1'b0;
            state_d = (win_ws == '0) ? ACTIVE : WAIT;
          end else begin
            cs_d    = '1;
            err_d   = 1'b1;
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end
        WAIT: begin
          ready_d = 1'b0;
          cnt_d   = cnt - WSW'(1);
          if (cnt <= WSW'(1)) state_d = ACTIVE;
        end
        ACTIVE: begin
          // ready is registered one cycle behind entry to ACTIVE, giving ws+2 latency.
          if (bus_done) begin
            cs_d    = '1;
            ready_d = 1'b0;
            state_d = IDLE;
          end else begin
            ready_d = 1'b1;
          end
        end
        default: begin
          cs_d    = '1;
          ready_d = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cs     <= '1;
      ready  <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
      addr_q <= '0;
      mio_q  <= 1'b0;
    end else begin
      state <= state_d;
      cs    <= cs_d;
      ready <= ready_d;
      err   <= err_d;
      cnt   <= cnt_d;
      if (ALE) begin
        addr_q <= address;
        mio_q  <= MIO;
      end
    end
  end

endmodule

// File: tb/tb_addr_decoder_ws.sv
// Scoreboard bench for addr_decoder_ws: each driven cycle queues the expected
// post-edge outputs, and a negedge monitor pops and compares them.
module tb_addr_decoder_ws;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        MIO, ALE, bus_done;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [15:0] cfg_base, cfg_mask;
  logic        cfg_mio;
  logic [3:0]  cfg_ws;
  logic        cfg_en;
  logic [7:0]  cs;
  logic        ready, err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] cs;
    logic       ready;
    logic       err;
  } exp_t;

  exp_t sbq[$];

  always #5 clock = ~clock;

  addr_decoder_ws #(.AW(16), .NCS(8), .WSW(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .MIO      (MIO),
    .ALE      (ALE),
    .bus_done (bus_done),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_base (cfg_base),
    .cfg_mask (cfg_mask),
    .cfg_mio  (cfg_mio),
    .cfg_ws   (cfg_ws),
    .cfg_en   (cfg_en),
    .cs       (cs),
    .ready    (ready),
    .err      (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clock) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check_eq({e.tag, ".cs"},    32'(cs),    32'(e.cs));
      check_eq({e.tag, ".ready"}, 32'(ready), 32'(e.ready));
      check_eq({e.tag, ".err"},   32'(err),   32'(e.err));
    end
  end

  task automatic step(input string tag, input logic ale_v, input logic [15:0] a,
                      input logic m, input logic bd,
                      input logic [7:0] ecs, input logic erdy, input logic eerr);
    exp_t e;
    ALE      = ale_v;
    address  = a;
    MIO      = m;
    bus_done = bd;
    e.tag = tag; e.cs = ecs; e.ready = erdy; e.err = eerr;
    sbq.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [15:0] base, input logic [15:0] mask,
                           input logic m, input logic [3:0] ws, input logic en,
                           input string tag, input logic [7:0] ecs, input logic erdy, input logic eerr);
    cfg_we = 1'b1; cfg_idx = idx; cfg_base = base; cfg_mask = mask;
    cfg_mio = m; cfg_ws = ws; cfg_en = en;
    step(tag, 1'b0, 16'h0000, 1'b0, 1'b0, ecs, erdy, eerr);
    cfg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = '0; MIO = 1'b0; ALE = 1'b0; bus_done = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_mask = '0;
    cfg_mio = 1'b0; cfg_ws = '0; cfg_en = 1'b0;

    // Reset, including ALE held during reset
    step("rst0",    0, 16'h0000, 0, 0, 8'hFF, 0, 0);
    step("rst_ale", 1, 16'h0400, 1, 1, 8'hFF, 0, 0);
    reset = 1'b0;
    step("idle0",   0, 16'h0000, 0, 1, 8'hFF, 0, 0);

    cfg_write(4'd0, 16'h0400, 16'h0C00, 1, 4'd0, 1, "cfg0", 8'hFF, 0, 0);
    cfg_write(4'd1, 16'h0800, 16'h0C00, 1, 4'd3, 1, "cfg1", 8'hFF, 0, 0);
    cfg_write(4'd2, 16'h0000, 16'h0009, 0, 4'd1, 1, "cfg2", 8'hFF, 0, 0);
    cfg_write(4'd3, 16'h0000, 16'h0009, 0, 4'd0, 1, "cfg3", 8'hFF, 0, 0);
    // Out-of-range indices: would match everything if not dropped
    cfg_write(4'd8,  16'h0000, 16'h0000, 1, 4'd0, 1, "cfg8",  8'hFF, 0, 0);
    cfg_write(4'd15, 16'h0000, 16'h0000, 1, 4'd0, 1, "cfg15", 8'hFF, 0, 0);

    step("oor_ale",  1, 16'h0000, 1, 0, 8'hFF, 0, 0);
    step("oor_dec",  0, 16'h0000, 0, 0, 8'hFF, 1, 1);
    step("oor_idle", 0, 16'h0000, 0, 0, 8'hFF, 0, 0);

    // Region 0, ws=0
    step("r0_ale",  1, 16'h0512, 1, 0, 8'hFF, 0, 0);
    step("r0_dec",  0, 16'h0000, 0, 0, 8'hFE, 0, 0);
    step("r0_rdy",  0, 16'h0000, 0, 0, 8'hFE, 1, 0);
    step("r0_hold", 0, 16'h0000, 0, 0, 8'hFE, 1, 0);
    step("r0_done", 0, 16'h0000, 0, 1, 8'hFF, 0, 0);
    step("r0_idle", 0, 16'h0000, 0, 0, 8'hFF, 0, 0);

    // Region 1, ws=3; bus_done in WAIT ignored
    step("r1_ale",  1, 16'h09FF, 1, 0, 8'hFF, 0, 0);
    step("r1_dec",  0, 16'h0000, 0, 0, 8'hFD, 0, 0);
    step("r1_w1",   0, 16'h0000, 0, 1, 8'hFD, 0, 0);
    step("r1_w2",   0, 16'h0000, 0, 0, 8'hFD, 0, 0);
    step("r1_act",  0, 16'h0000, 0, 0, 8'hFD, 0, 0);
    step("r1_rdy",  0, 16'h0000, 0, 0, 8'hFD, 1, 0);
    step("r1_done", 0, 16'h0000, 0, 1, 8'hFF, 0, 0);

    // Overlapping I/O regions 2 and 3; region 2 wins (ws=1)
    step("io_ale",  1, 16'h0000, 0, 0, 8'hFF, 0, 0);
    step("io_dec",  0, 16'h0000, 0, 0, 8'hFB, 0, 0);
    step("io_w",    0, 16'h0000, 0, 0, 8'hFB, 0, 0);
    step("io_rdy",  0, 16'h0000, 0, 0, 8'hFB, 1, 0);
    step("io_done", 0, 16'h0000, 0, 1, 8'hFF, 0, 0);
    step("mem0_ale",  1, 16'h0000, 1, 0, 8'hFF, 0, 0);
    step("mem0_err",  0, 16'h0000, 0, 0, 8'hFF, 1, 1);
    step("mem0_idle", 0, 16'h0000, 0, 0, 8'hFF, 0, 0);

    // Abort during WAIT with a new ALE to region 0
    step("ab_ale",   1, 16'h09FF, 1, 0, 8'hFF, 0, 0);
    step("ab_dec",   0, 16'h0000, 0, 0, 8'hFD, 0, 0);
    step("ab_new",   1, 16'h0400, 1, 0, 8'hFF, 0, 0);
    step("ab_dec2",  0, 16'h0000, 0, 0, 8'hFE, 0, 0);
    step("ab_rdy",   0, 16'h0000, 0, 0, 8'hFE, 1, 0);
    // ALE beats bus_done in ACTIVE
    step("pri_ale",  1, 16'h09FF, 1, 1, 8'hFF, 0, 0);
    step("pri_dec",  0, 16'h0000, 0, 0, 8'hFD, 0, 0);
    // Disable region 1 mid-WAIT: access in progress is unaffected
    cfg_write(4'd1, 16'h0800, 16'h0C00, 1, 4'd0, 0, "cw_w1", 8'hFD, 0, 0);
    step("cw_w2",    0, 16'h0000, 0, 0, 8'hFD, 0, 0);
    step("cw_act",   0, 16'h0000, 0, 0, 8'hFD, 0, 0);
    step("cw_rdy",   0, 16'h0000, 0, 0, 8'hFD, 1, 0);
    step("cw_done",  0, 16'h0000, 0, 1, 8'hFF, 0, 0);
    step("cw_ale",   1, 16'h09FF, 1, 0, 8'hFF, 0, 0);
    step("cw_err",   0, 16'h0000, 0, 0, 8'hFF, 1, 1);

    // Same-edge disable of region 0 while decoding uses the old table
    step("se_ale",   1, 16'h0400, 1, 0, 8'hFF, 0, 0);
    cfg_write(4'd0, 16'h0400, 16'h0C00, 1, 4'd0, 0, "se_dec", 8'hFE, 0, 0);
    step("se_rdy",   0, 16'h0000, 0, 0, 8'hFE, 1, 0);
    step("se_done",  0, 16'h0000, 0, 1, 8'hFF, 0, 0);
    step("se_ale2",  1, 16'h0400, 1, 0, 8'hFF, 0, 0);
    step("se_err",   0, 16'h0000, 0, 0, 8'hFF, 1, 1);
    step("se_idle",  0, 16'h0000, 0, 0, 8'hFF, 0, 0);

    // Reset during ACTIVE clears outputs and the table
    step("ra_ale",   1, 16'h0000, 0, 0, 8'hFF, 0, 0);
    step("ra_dec",   0, 16'h0000, 0, 0, 8'hFB, 0, 0);
    step("ra_w",     0, 16'h0000, 0, 0, 8'hFB, 0, 0);
    step("ra_rdy",   0, 16'h0000, 0, 0, 8'hFB, 1, 0);
    reset = 1'b1;
    step("ra_rst",   0, 16'h0000, 0, 0, 8'hFF, 0, 0);
    reset = 1'b0;
    step("ra_ale2",  1, 16'h0400, 1, 0, 8'hFF, 0, 0);
    step("ra_err",   0, 16'h0000, 0, 0, 8'hFF, 1, 1);
    step("ra_ale3",  1, 16'h0000, 0, 0, 8'hFF, 0, 0);
    step("ra_err3",  0, 16'h0000, 0, 0, 8'hFF, 1, 1);

    // All-zero mask matches any address in its space
    cfg_write(4'd4, 16'h1234, 16'h0000, 0, 4'd0, 1, "m0_cfg", 8'hFF, 0, 0);
    step("m0_ale",   1, 16'hABCD, 0, 0, 8'hFF, 0, 0);
    step("m0_dec",   0, 16'h0000, 0, 0, 8'hEF, 0, 0);
    step("m0_rdy",   0, 16'h0000, 0, 0, 8'hEF, 1, 0);
    step("m0_done",  0, 16'h0000, 0, 1, 8'hFF, 0, 0);
    step("m0_mem",   1, 16'hABCD, 1, 0, 8'hFF, 0, 0);
    step("m0_err",   0, 16'h0000, 0, 0, 8'hFF, 1, 1);
    step("m0_idle",  0, 16'h0000, 0, 0, 8'hFF, 0, 0);

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clock);
    #1;
    if (sbq.size() > 0) check_eq("drain", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addr_decoder_ws.md
ADDR_DECODER_WS -- requirements
Module: addr_decoder_ws

Interface
REQ-001 Parameter AW, default 16, address width in bits.
REQ-002 Parameter NCS, default 8, number of chip-select regions (2..16).
REQ-003 Parameter WSW, default 4, wait-state counter width in bits.
REQ-004 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  AW  bus address, sampled only when ALE=1.
REQ-007 MIO  input  1  1=memory cycle, 0=I/O cycle, sampled with address.
REQ-008 ALE  input  1  address latch enable, starts a bus cycle.
REQ-009 bus_done  input  1  one-cycle pulse ending the current access.
REQ-010 cfg_we  input  1  region configuration write strobe.
REQ-011 cfg_idx  input  4  region index to write.
REQ-012 cfg_base  input  AW  region base address.
REQ-013 cfg_mask  input  AW  compare mask (1 = bit compared, 0 = don't-care).
REQ-014 cfg_mio  input  1  region space (1 = memory, 0 = I/O).
REQ-015 cfg_ws  input  WSW  wait states for the region.
REQ-016 cfg_en  input  1  region enable.
REQ-017 cs  output  NCS  chip selects, active low, at most one bit low.
REQ-018 ready  output  1  access may complete (high = no wait).
REQ-019 err  output  1  one-cycle pulse: latched address matched no region.

Function
REQ-020 A region SHALL match when enabled, cfg_mio equals latched MIO, and ((addr_q XOR base) AND mask) = 0.
REQ-021 On overlapping matches, the lowest region index SHALL win.
REQ-022 The FSM SHALL have the states IDLE, DECODE, WAIT and ACTIVE.
REQ-023 IDLE: with ALE=1, the block SHALL latch address/MIO into addr_q/mio_q and go to DECODE; with ALE=0 it SHALL stay in IDLE with cs all ones and ready=0.
REQ-024 DECODE (one cycle), on a hit: cs[winner] SHALL go low on the next edge and the counter SHALL load cfg_ws of the winner; the next state SHALL be ACTIVE if ws=0, else WAIT.
REQ-025 DECODE on a miss: cs SHALL stay all ones, err=1 and ready=1 for exactly one cycle, then IDLE.
REQ-026 WAIT: cs SHALL be held, ready=0 and the counter SHALL decrement each cycle; at count 1 the next state SHALL be ACTIVE.
REQ-027 Latency: ready SHALL rise ws+2 cycles after the ALE sample edge (ws=0 gives 2 cycles).
REQ-028 ACTIVE: cs and ready=1 SHALL be held until bus_done=1; the next edge SHALL then give cs all ones, ready=0 and IDLE.
REQ-029 ALE=1 in DECODE, WAIT or ACTIVE SHALL abort the current access: cs goes all ones, the new address is latched, and the next state is DECODE; ALE takes priority over bus_done.
REQ-030 bus_done in IDLE, DECODE or WAIT SHALL be ignored.
REQ-031 cfg_we SHALL update the region table on its edge; a decode on that same edge SHALL use the old table contents.
REQ-032 Configuration writes during WAIT or ACTIVE SHALL NOT alter the cs or counter of the cycle in progress.
REQ-033 cfg_idx >= NCS SHALL be ignored, with no state change.
REQ-034 A mask of all zeros SHALL match every address in the region's space.

Reset
REQ-035 reset=1 SHALL, on the next edge and overriding all other inputs, give: state=IDLE, cs all ones, ready=0, err=0, counter=0, addr_q=0, mio_q=0, all regions disabled (base=0, mask=0, ws=0).
REQ-036 Reset asserted mid-access (WAIT or ACTIVE) SHALL release cs on the next edge, with no err pulse.

Verification
REQ-037 Config region 0 = {base 0x0400, mask 0x0C00, mem, ws 0, en}; ALE, address 0x0512, MIO=1 -> cs=0xFE and ready=1 two cycles after ALE; bus_done -> cs=0xFF, ready=0.
REQ-038 Region 1 = {base 0x0800, mask 0x0C00, mem, ws 3}; access 0x09FF -> cs=0xFD, ready low 3 cycles, high at cycle 5.
REQ-039 Regions 2 and 3 both cover I/O 0x0000 with mask 0x0009; I/O access 0x0000 -> cs=0xFB (lowest index wins); the same address with MIO=1 -> err pulse, cs=0xFF.
REQ-040 During WAIT of REQ-038, assert ALE with 0x0400 -> region 1 cs released next edge, cs=0xFE two cycles after the new ALE.
REQ-041 Same-edge cfg_we disabling region 0 and a DECODE of 0x0400 -> access still hits region 0; the next access to 0x0400 -> err.
REQ-042 reset during ACTIVE -> cs=0xFF, ready=0, err=0 next edge; a later access to 0x0400 -> err (table cleared).
